// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
// Holds the default specifier width, the FSM state type and source-valid bit indices.
package pipe_ctrl_pkg;

    localparam int DEF_REG_W = 4;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } ctrl_state_t;

    localparam int SRC_RN = 0;
    localparam int SRC_RM = 1;
    localparam int SRC_RD = 2;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID source that needs the result of a load in EX.
// Ports: id_rn/id_rm/id_rd + id_src_valid (ID sources), ex_rd/ex_rf_enable/
//        ex_load_instruction (EX producer), load_use (hazard out).
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic [2:0]       id_src_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_enable,
    input  logic             ex_load_instruction,
    output logic             load_use
);

    logic hit_rn;
    logic hit_rm;
    logic hit_rd;

    assign hit_rn = id_src_valid[SRC_RN] && (id_rn == ex_rd);
    assign hit_rm = id_src_valid[SRC_RM] && (id_rm == ex_rd);
    assign hit_rd = id_src_valid[SRC_RD] && (id_rd == ex_rd);

    assign load_use = ex_load_instruction && ex_rf_enable
                   && (hit_rn || hit_rm || hit_rd);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: stage load enables, NOP select and IF/ID flush around
// load-use hazards, taken branches and multi-cycle memory accesses (with timeout halt).
// Ports: clk, reset (async high); ID/EX hazard inputs; branch_taken; mem_req/mem_ready;
//        le_* enables, nop_insertion_selection, flush_if_id; mem_timeout, ctrl_state;
//        stall_cycles/freeze_cycles/flush_count (live only with PIPE_PERF_CNT_EN defined).
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = DEF_REG_W,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic [2:0]       id_src_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_enable,
    input  logic             ex_load_instruction,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             le_pc,
    output logic             le_if_id,
    output logic             le_id_ex,
    output logic             le_ex_mem,
    output logic             le_mem_wb,
    output logic             nop_insertion_selection,
    output logic             flush_if_id,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    logic load_use;
    logic freeze;
    logic run_decode;
    logic bubble;
    logic flush;

    load_use_detect #(.REG_W(REG_W)) u_lud (
        .id_rn               (id_rn),
        .id_rm               (id_rm),
        .id_rd               (id_rd),
        .id_src_valid        (id_src_valid),
        .ex_rd               (ex_rd),
        .ex_rf_enable        (ex_rf_enable),
        .ex_load_instruction (ex_load_instruction),
        .load_use            (load_use)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        freeze     = 1'b0;
        run_decode = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = WAIT_ONE;
                    state_d    = MEM_WAIT;
                end else begin
                    run_decode = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    run_decode = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    freeze    = 1'b1;
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                freeze  = 1'b1;
                state_d = RUN;
            end
        endcase
    end

    // A load-use bubble suppresses a same-cycle flush; the branch stays in ID.
    assign bubble = run_decode && load_use;
    assign flush  = run_decode && !load_use && branch_taken;

    assign le_pc     = !freeze && !bubble;
    assign le_if_id  = !freeze && !bubble;
    assign le_id_ex  = !freeze;
    assign le_ex_mem = !freeze;
    assign le_mem_wb = !freeze;

    assign nop_insertion_selection = bubble;
    assign flush_if_id             = flush;
    assign mem_timeout             = timeout_q;
    assign ctrl_state              = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] frz_q, frz_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // All counters saturate at all-ones.
    always_comb begin
        stall_d = stall_q;
        frz_d   = frz_q;
        flush_d = flush_q;
        if (bubble && stall_q != '1) stall_d = stall_q + 1'b1;
        if (freeze && frz_q != '1)   frz_d   = frz_q + 1'b1;
        if (flush && flush_q != '1)  flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            frz_q   <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            frz_q   <= frz_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign freeze_cycles = frz_q;
    assign flush_count   = flush_q;
`else
    assign stall_cycles  = '0;
    assign freeze_cycles = '0;
    assign flush_count   = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller.
// Counter expectations follow PIPE_PERF_CNT_EN (zero when the counters are compiled out).
module tb_pipeline_stall_controller;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  id_rn, id_rm, id_rd, ex_rd;
    logic [2:0]  id_src_valid;
    logic        ex_rf_enable, ex_load_instruction;
    logic        branch_taken, mem_req, mem_ready;
    logic        le_pc, le_if_id, le_id_ex, le_ex_mem, le_mem_wb;
    logic        nop_insertion_selection, flush_if_id, mem_timeout;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles, freeze_cycles, flush_count;

    logic [4:0]  les;
    int          n_run;
    int          n_fail;
    int          exp_stall;
    int          exp_frz;
    int          exp_flush;

    pipeline_stall_controller #(
        .REG_W       (4),
        .MEM_TIMEOUT (8),
        .CNT_W       (16)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .id_rn                   (id_rn),
        .id_rm                   (id_rm),
        .id_rd                   (id_rd),
        .id_src_valid            (id_src_valid),
        .ex_rd                   (ex_rd),
        .ex_rf_enable            (ex_rf_enable),
        .ex_load_instruction     (ex_load_instruction),
        .branch_taken            (branch_taken),
        .mem_req                 (mem_req),
        .mem_ready               (mem_ready),
        .le_pc                   (le_pc),
        .le_if_id                (le_if_id),
        .le_id_ex                (le_id_ex),
        .le_ex_mem               (le_ex_mem),
        .le_mem_wb               (le_mem_wb),
        .nop_insertion_selection (nop_insertion_selection),
        .flush_if_id             (flush_if_id),
        .mem_timeout             (mem_timeout),
        .ctrl_state              (ctrl_state),
        .stall_cycles            (stall_cycles),
        .freeze_cycles           (freeze_cycles),
        .flush_count             (flush_count)
    );

    assign les = {le_pc, le_if_id, le_id_ex, le_ex_mem, le_mem_wb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".stall"}, 32'(stall_cycles), ev(exp_stall));
        chk({tag, ".frz"}, 32'(freeze_cycles), ev(exp_frz));
        chk({tag, ".flush"}, 32'(flush_count), ev(exp_flush));
    endtask

    task automatic idle_inputs();
        id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0; ex_rd = 4'd0;
        id_src_valid = 3'b000;
        ex_rf_enable = 1'b0; ex_load_instruction = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        exp_stall = 0; exp_frz = 0; exp_flush = 0;
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst.state", 32'(ctrl_state), 32'd0);
        chk("rst.tmo", 32'(mem_timeout), 32'd0);
        chk("rst.les", 32'(les), 32'h1f);
        chk_cnt("rst");
        reset = 1'b0;
        step();

        // Load-use on Rm
        ex_load_instruction = 1'b1; ex_rf_enable = 1'b1;
        ex_rd = 4'd3; id_rm = 4'd3; id_src_valid = 3'b010;
        #1;
        chk("lu.les", 32'(les), 32'h07);
        chk("lu.nop", 32'(nop_insertion_selection), 32'd1);
        chk("lu.flush", 32'(flush_if_id), 32'd0);
        step(); exp_stall++;
        chk_cnt("lu");

        // Same producer, no valid sources
        id_src_valid = 3'b000;
        #1;
        chk("nv.les", 32'(les), 32'h1f);
        chk("nv.nop", 32'(nop_insertion_selection), 32'd0);
        step();
        chk_cnt("nv");

        // Rn differs only in MSB: full-width compare must miss
        id_rn = 4'd11; id_src_valid = 3'b001;
        #1;
        chk("msb.les", 32'(les), 32'h1f);
        step();

        // Rd match
        id_rd = 4'd3; id_src_valid = 3'b100;
        #1;
        chk("rd.nop", 32'(nop_insertion_selection), 32'd1);
        step(); exp_stall++;

        // Producer does not write the register file
        ex_rf_enable = 1'b0;
        #1;
        chk("norf.nop", 32'(nop_insertion_selection), 32'd0);
        step();

        // Load-use together with taken branch: flush suppressed
        ex_rf_enable = 1'b1; id_src_valid = 3'b010; branch_taken = 1'b1;
        #1;
        chk("lub.flush", 32'(flush_if_id), 32'd0);
        chk("lub.les", 32'(les), 32'h07);
        step(); exp_stall++;

        // Branch alone
        ex_load_instruction = 1'b0;
        #1;
        chk("br.flush", 32'(flush_if_id), 32'd1);
        chk("br.les", 32'(les), 32'h1f);
        step(); exp_flush++;
        chk_cnt("br");
        idle_inputs();

        // Memory access ready on 3rd frozen cycle
        mem_req = 1'b1;
        #1;
        chk("m1.les", 32'(les), 32'h00);
        chk("m1.state", 32'(ctrl_state), 32'd0);
        step(); exp_frz++;
        chk("m2.state", 32'(ctrl_state), 32'd1);
        chk("m2.les", 32'(les), 32'h00);
        step(); exp_frz++;
        mem_ready = 1'b1;
        #1;
        chk("m3.les", 32'(les), 32'h1f);
        chk("m3.state", 32'(ctrl_state), 32'd1);
        step();
        chk("m4.state", 32'(ctrl_state), 32'd0);
        chk_cnt("mem");
        idle_inputs();
        step();

        // Timeout: 8 frozen cycles then HALT
        mem_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk($sformatf("to%0d.les", i), 32'(les), 32'h00);
            chk($sformatf("to%0d.tmo", i), 32'(mem_timeout), 32'd0);
            chk($sformatf("to%0d.st", i), 32'(ctrl_state),
                (i == 1) ? 32'd0 : 32'd1);
            step(); exp_frz++;
        end
        chk("halt.state", 32'(ctrl_state), 32'd2);
        chk("halt.tmo", 32'(mem_timeout), 32'd1);
        chk("halt.les", 32'(les), 32'h00);
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(); exp_frz++;
        end
        chk("halt20.state", 32'(ctrl_state), 32'd2);
        chk("halt20.les", 32'(les), 32'h00);
        chk("halt20.tmo", 32'(mem_timeout), 32'd1);
        chk_cnt("halt20");

        // Reset while halted
        reset = 1'b1;
        #1;
        exp_stall = 0; exp_frz = 0; exp_flush = 0;
        chk("rh.state", 32'(ctrl_state), 32'd0);
        chk("rh.tmo", 32'(mem_timeout), 32'd0);
        chk("rh.les", 32'(les), 32'h1f);
        chk_cnt("rh");
        #2;
        reset = 1'b0;
        idle_inputs();
        step();

        // Reset mid-MEM_WAIT
        mem_req = 1'b1;
        step(); exp_frz++;
        step(); exp_frz++;
        chk("mw.state", 32'(ctrl_state), 32'd1);
        chk_cnt("mw");
        mem_req = 1'b0;
        reset = 1'b1;
        #1;
        exp_stall = 0; exp_frz = 0; exp_flush = 0;
        chk("rw.state", 32'(ctrl_state), 32'd0);
        chk("rw.les", 32'(les), 32'h1f);
        chk_cnt("rw");
        #2;
        reset = 1'b0;
        step();

        // Normal RUN decode after reset
        ex_load_instruction = 1'b1; ex_rf_enable = 1'b1;
        ex_rd = 4'd5; id_rn = 4'd5; id_src_valid = 3'b001;
        #1;
        chk("post.les", 32'(les), 32'h07);
        step(); exp_stall++;
        chk("post.state", 32'(ctrl_state), 32'd0);
        chk_cnt("post");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Sequences the five-stage pipeline's latch enables around three events: load-use hazards, taken-branch flushes and multi-cycle data-memory accesses. It sits beside the hazards/forwarding unit and owns every stage load-enable, the ID→EX NOP-insertion select and the IF/ID flush. A small FSM freezes the whole pipeline while the data memory is busy. It enters a terminal halt if memory never answers.

## Interface
Parameters:
- REG_W, 4, register-specifier width
- MEM_TIMEOUT, 8, maximum frozen cycles per memory access before halt (legal range ≥2)
- CNT_W, 16, performance-counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- id_rn, id_rm, id_rd  in  REG_W each  source specifiers of the instruction in ID
- id_src_valid  in  3  per-source use flags: bit0 = Rn, bit1 = Rm, bit2 = Rd
- ex_rd  in  REG_W  destination of the instruction in EX
- ex_rf_enable  in  1  EX instruction writes the register file
- ex_load_instruction  in  1  EX instruction is a load
- branch_taken  in  1  ID branch resolved taken
- mem_req  in  1  MEM stage holds a load/store
- mem_ready  in  1  data memory completes the access this cycle
- le_pc, le_if_id, le_id_ex, le_ex_mem, le_mem_wb  out  1 each  stage load enables
- nop_insertion_selection  out  1  selects NOP into ID/EX
- flush_if_id  out  1  clears IF/ID on the next edge
- mem_timeout  out  1  sticky; set on entry to HALT
- ctrl_state  out  2  RUN = 00, MEM_WAIT = 01, HALT = 10
- stall_cycles, freeze_cycles, flush_count  out  CNT_W each  performance counters

## Operation
- **load_use** = ex_load_instruction & ex_rf_enable & any valid source equal to ex_rd.
- **freeze** = all five le_* at 0, nop_insertion_selection = 0, flush_if_id = 0.
- **Event priority:** freeze > load_use > branch flush.
- **RUN** (evaluated in priority order):
  - mem_req & !mem_ready → freeze. wait_cnt ← 1. Next state MEM_WAIT.
  - load_use → le_pc = le_if_id = 0; nop_insertion_selection = 1; downstream le_* = 1. Stay in RUN. The hazard clears itself after one bubble because the load advances to MEM.
  - branch_taken → all le_* = 1, flush_if_id = 1.
  - Otherwise → all le_* = 1, other outputs 0.
- **Simultaneous events:**
  - load_use & branch_taken → flush suppressed. The branch is re-evaluated next cycle while it is still held in ID.
- **MEM_WAIT:**
  - mem_ready → outputs as RUN with the freeze term removed. wait_cnt ← 0. Next state RUN.
  - !mem_ready & wait_cnt+1 == MEM_TIMEOUT → freeze. Next state HALT; mem_timeout ← 1.
  - Otherwise → freeze. wait_cnt ← wait_cnt+1.
- **HALT:** freeze permanently. Only reset exits.
- **Width rules:**
  - wait_cnt is $clog2(MEM_TIMEOUT+1) bits and never wraps.
  - Specifier compares are full REG_W equality.

## Timing
- Stage enables, NOP select and flush are combinational from state and current inputs, giving zero-cycle stall response.
- ctrl_state, wait_cnt, mem_timeout and the counters are registered.
- **Reset** (asynchronous, takes effect immediately):
  - ctrl_state = RUN, wait_cnt = 0, mem_timeout = 0, counters = 0.
  - Outputs return to the RUN decode of the current inputs.
- **Reset mid-MEM_WAIT or in HALT:** returns to RUN with no residual freeze.
- **Memory latency:** an access with mem_ready on the N-th frozen cycle (counted from the RUN cycle as 1) freezes for exactly N−1 cycles. The pipeline advances on the N-th edge.
- **Timeout:** with no mem_ready, MEM_TIMEOUT frozen cycles occur. HALT and mem_timeout are visible on cycle MEM_TIMEOUT+1.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments on each load_use bubble cycle.
  - freeze_cycles increments on each freeze cycle, including HALT.
  - flush_count increments on each asserted flush_if_id.
  - All three saturate at all-ones.
- Undefined: counter registers are removed and the three ports are driven constant 0. Control behaviour is identical either way.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - REG_W default
  - the ctrl_state_t enum (RUN, MEM_WAIT, HALT, 2-bit encoded as above)
  - the source-valid bit-index constants
- One sub-module, load_use_detect: combinational compare of the three sources against ex_rd, producing load_use.
- FSM, wait counter and performance counters stay in the top.

## Test plan
- ex_load_instruction = 1, ex_rf_enable = 1, ex_rd = 3, id_rm = 3, id_src_valid = 010 → that cycle le_pc = le_if_id = 0, nop_insertion_selection = 1, le_id_ex = 1; stall_cycles = 1 after the edge.
- Same as above but id_src_valid = 000 → no stall, all le_* = 1.
- branch_taken with load_use in the same cycle → flush_if_id = 0. Next cycle branch_taken alone → flush_if_id = 1; flush_count = 1.
- mem_req = 1, mem_ready asserted on the 3rd frozen cycle → exactly 2 edges with all le_* = 0, ctrl_state = 01, then RUN; freeze_cycles = 2.
- MEM_TIMEOUT = 8, mem_req = 1, mem_ready held 0 → 8 frozen cycles, then ctrl_state = 10 and mem_timeout = 1 from cycle 9; still halted 20 cycles later.
- Reset pulsed while in MEM_WAIT and again in HALT → immediately ctrl_state = 00, mem_timeout = 0, counters = 0; the normal RUN decode resumes.
